xtor_rr_arbiter: RTL and testbench
==================================

Name: xtor_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one transactor core (valid/ready in, registered data_i+1 out, one-cycle result latency) among NUM_REQ requesters.
- Accepts one request at a time, issues it to the core and captures the core result.
- Returns the result to the granted requester over a per-requester response handshake.
- Sits between the requester-side agents and the single core instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_W, 32, width of request and response data; must match the core data width.
- CNT_W, 16, width of the completed-transaction counter.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester request accept.
- req_data  input  NUM_REQ*DATA_W  request payloads, requester i at bits [i*DATA_W +: DATA_W].
- rsp_valid  output  NUM_REQ  per-requester response valid.
- rsp_ready  input  NUM_REQ  per-requester response accept.
- rsp_data  output  DATA_W  response payload, shared; meaningful only where rsp_valid is set.
- core_valid  output  1  valid to the core.
- core_ready  input  1  ready from the core.
- core_wdata  output  DATA_W  to core data_i.
- core_rdata  input  DATA_W  from core data_o.
- busy  output  1  high whenever state != IDLE.
- grant_id  output  $clog2(NUM_REQ)  index of the current or last grantee.
- txn_count  output  CNT_W  completed responses since reset.

Behaviour:
- Reset (synchronous, active-high, sampled on the clock edge) returns all state to defaults:
  - state = IDLE.
  - req_ready, rsp_valid, core_valid, busy = 0.
  - core_wdata, rsp_data, txn_count = 0.
  - grant_id = NUM_REQ-1, so requester 0 has first priority.
- Reset mid-operation aborts the transaction silently; no response is produced.
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Search req_valid starting at (grant_id+1) mod NUM_REQ, wrapping.
  - First asserted index g wins. req_ready[g]=1 combinationally in this cycle only.
  - At the edge: latch req_data[g] into core_wdata, set grant_id=g, go to ISSUE.
  - If no req_valid, stay in IDLE. Never more than one req_ready bit high.
- ISSUE:
  - core_valid=1; core_wdata held stable.
  - At an edge with core_ready=1: core_valid drops and state goes to WAIT.
  - Otherwise hold indefinitely.
- WAIT:
  - Exactly one cycle.
  - core_rdata now carries the result; at the edge latch it into rsp_data and go to RESP.
- RESP:
  - rsp_valid[grant_id]=1, all other bits 0; rsp_data stable.
  - At an edge with rsp_ready[grant_id]=1: txn_count += 1 (wraps modulo 2^CNT_W), go to IDLE.
  - rsp_ready of non-granted requesters is ignored.
- Throughput and latency:
  - Best case is 4 cycles per transaction, with core_ready and rsp_ready high.
  - Request accept to rsp_valid is 3 cycles.
  - The next grant may occur in the cycle after the RESP handshake.
- Fairness: the requester just served has lowest priority in the next IDLE search.
  - With all requesters continuously valid, the grant order is 0,1,2,...,NUM_REQ-1,0,...
- req_valid deasserting before grant is permitted; that request is simply not considered.
- After the core leaves reset, its ready is low for one cycle; ISSUE waits for it.
- Data is passed through unmodified in both directions; no arithmetic is done in this block.

Test Plan:
- Reset then single request: req_valid[1]=1, req_data[1]=0x10, core ready.
  - req_ready[1] pulses for 1 cycle; core_valid the next cycle.
  - rsp_valid[1] 3 cycles after accept with rsp_data=0x11; txn_count=1 after rsp_ready[1].
- All four requesters valid continuously with data 0x100+i.
  - Grants in order 0,1,2,3,0; responses 0x101,0x102,0x103,0x104,0x101.
  - busy stays high except one IDLE cycle between transactions.
- Core backpressure: hold core_ready=0 for 5 cycles in ISSUE.
  - core_valid and core_wdata stay stable; WAIT entered only after core_ready=1.
  - Result is still data+1.
- Response backpressure: rsp_ready[2]=0 for 6 cycles, while rsp_ready of other requesters is toggled.
  - rsp_valid[2] and rsp_data held; no new grant; txn_count unchanged until rsp_ready[2]=1.
- Reset asserted in WAIT with an outstanding request from requester 3.
  - Next cycle: all outputs at reset values, no rsp_valid, grant_id=NUM_REQ-1.
  - A new request from requester 0 completes normally.
- Counter wrap with CNT_W=4: 16 back-to-back transactions -> txn_count returns to 0.
  - Data integrity holds throughout, with random req_data checked against +1.

Source files
------------

// File: rtl/xtor_rr_arbiter.sv
// Round-robin arbiter that time-shares one valid/ready transactor core among NUM_REQ
// requesters: accept one request, issue it to the core, return the result to its owner.
module xtor_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         rsp_valid,
    input  logic [NUM_REQ-1:0]         rsp_ready,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       core_valid,
    input  logic                       core_ready,
    output logic [DATA_W-1:0]          core_wdata,
    input  logic [DATA_W-1:0]          core_rdata,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic [CNT_W-1:0]           txn_count
);
    localparam int unsigned     ID_W    = $clog2(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state, state_d;
    logic [DATA_W-1:0] wdata_d, rdata_d;
    logic [ID_W-1:0]   gid_d, pick;
    logic [CNT_W-1:0]  cnt_d;
    logic              found;
    logic [DATA_W-1:0] req_word [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_word[i] = req_data[i*DATA_W +: DATA_W];
    end

    // Rotating search starting just after the last grantee, so it has lowest priority
    always_comb begin
        logic [ID_W-1:0] cand;
        found = 1'b0;
        pick  = grant_id;
        cand  = grant_id;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((32'(grant_id) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Next-state and accept logic; req_ready is only ever high in IDLE out of reset
    always_comb begin
        state_d   = state;
        wdata_d   = core_wdata;
        rdata_d   = rsp_data;
        gid_d     = grant_id;
        cnt_d     = txn_count;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (found && !reset) begin
                    req_ready[pick] = 1'b1;
                    wdata_d         = req_word[pick];
                    gid_d           = pick;
                    state_d         = ISSUE;
                end
            end
            ISSUE: begin
                if (core_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                rdata_d = core_rdata;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready[grant_id]) begin
                    cnt_d   = txn_count + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs, decoded from the next state
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            core_wdata <= '0;
            rsp_data   <= '0;
            grant_id   <= LAST_ID;
            txn_count  <= '0;
            core_valid <= 1'b0;
            busy       <= 1'b0;
            rsp_valid  <= '0;
        end else begin
            state      <= state_d;
            core_wdata <= wdata_d;
            rsp_data   <= rdata_d;
            grant_id   <= gid_d;
            txn_count  <= cnt_d;
            core_valid <= (state_d == ISSUE);
            busy       <= (state_d != IDLE);
            rsp_valid  <= (state_d == RESP) ? (NUM_REQ'(1) << gid_d) : '0;
        end
    end
endmodule

// File: tb/tb_xtor_rr_arbiter.sv
// Bench for xtor_rr_arbiter: core model plus a grant/data/count reference computed from
// the round-robin rules, exercised by one task per scenario.
module tb_xtor_rr_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*DW-1:0] req_data;
    logic [DW-1:0]   rsp_data, core_wdata, core_rdata;
    logic            core_valid, core_ready, busy;
    logic [1:0]      grant_id;
    logic [CW-1:0]   txn_count;
    logic            core_up, stall;

    int checks   = 0;
    int failures = 0;
    int model_last;
    int model_cnt;

    xtor_rr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .core_valid(core_valid), .core_ready(core_ready),
        .core_wdata(core_wdata), .core_rdata(core_rdata),
        .busy(busy), .grant_id(grant_id), .txn_count(txn_count)
    );

    always #5 clock = ~clock;

    // Transactor core: ready low for one cycle after reset, result = data + 1 one cycle later
    always @(posedge clock) begin
        core_up <= !reset;
        if (reset) core_rdata <= '0;
        else if (core_valid && core_ready) core_rdata <= core_wdata + 32'd1;
    end
    assign core_ready = core_up && !stall;

    function automatic int winner(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= int'(N); k++) begin
            if (v[(last + k) % int'(N)]) return (last + k) % int'(N);
        end
        return -1;
    endfunction

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic set_word(input int i, input logic [DW-1:0] d);
        req_data[i*DW +: DW] = d;
    endtask

    task automatic apply_reset();
        reset = 1'b1; req_valid = '0; rsp_ready = '1; stall = 1'b0;
        tick; tick;
        reset = 1'b0;
        model_last = N - 1;
        model_cnt  = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = '0; rsp_ready = '1; stall = 1'b0; req_data = '0;
        tick; tick; #1;
        checks++; if (req_ready !== 4'b0)  begin failures++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        checks++; if (rsp_valid !== 4'b0)  begin failures++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
        checks++; if (core_valid !== 1'b0) begin failures++; $display("FAIL reset_core_valid: got %b expected 0", core_valid); end
        checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (core_wdata !== 32'h0) begin failures++; $display("FAIL reset_core_wdata: got %0h expected 0", core_wdata); end
        checks++; if (rsp_data !== 32'h0)  begin failures++; $display("FAIL reset_rsp_data: got %0h expected 0", rsp_data); end
        checks++; if (txn_count !== 4'h0)  begin failures++; $display("FAIL reset_txn_count: got %0d expected 0", txn_count); end
        checks++; if (grant_id !== 2'(N - 1)) begin failures++; $display("FAIL reset_grant_id: got %0d expected %0d", grant_id, N - 1); end
        reset = 1'b0;
        model_last = N - 1;
        model_cnt  = 0;
        tick;
    endtask

    task automatic test_single();
        int g;
        rsp_ready = '1; stall = 1'b0; req_valid = '0;
        tick;
        set_word(1, 32'h10); req_valid = 4'b0010; #1;
        g = winner(req_valid, model_last);
        checks++; if (req_ready !== (N'(1) << g)) begin failures++; $display("FAIL single_accept: got %b expected %b", req_ready, N'(1) << g); end
        tick; req_valid = '0; model_last = g; #1;
        checks++; if (req_ready !== 4'b0)   begin failures++; $display("FAIL single_ready_pulse: got %b expected 0000", req_ready); end
        checks++; if (core_valid !== 1'b1)  begin failures++; $display("FAIL single_core_valid: got %b expected 1", core_valid); end
        checks++; if (core_wdata !== 32'h10) begin failures++; $display("FAIL single_core_wdata: got %0h expected 10", core_wdata); end
        checks++; if (grant_id !== 2'(g))   begin failures++; $display("FAIL single_grant_id: got %0d expected %0d", grant_id, g); end
        tick;
        checks++; if (core_valid !== 1'b0 || busy !== 1'b1 || rsp_valid !== 4'b0) begin failures++; $display("FAIL single_wait: got cv=%b busy=%b rv=%b expected cv=0 busy=1 rv=0000", core_valid, busy, rsp_valid); end
        tick;
        checks++; if (rsp_valid !== (N'(1) << g)) begin failures++; $display("FAIL single_rsp_valid: got %b expected %b", rsp_valid, N'(1) << g); end
        checks++; if (rsp_data !== 32'h11) begin failures++; $display("FAIL single_rsp_data: got %0h expected 11", rsp_data); end
        tick; model_cnt = (model_cnt + 1) % 16;
        checks++; if (txn_count !== CW'(model_cnt)) begin failures++; $display("FAIL single_txn_count: got %0d expected %0d", txn_count, model_cnt); end
        checks++; if (busy !== 1'b0 || rsp_valid !== 4'b0) begin failures++; $display("FAIL single_idle: got busy=%b rv=%b expected 0 0000", busy, rsp_valid); end
    endtask

    task automatic test_round_robin();
        int g, lat;
        apply_reset();
        for (int i = 0; i < int'(N); i++) set_word(i, 32'h100 + 32'(i));
        req_valid = '1;
        for (int t = 0; t < 5; t++) begin
            #1; g = winner(req_valid, model_last);
            checks++; if (req_ready !== (N'(1) << g)) begin failures++; $display("FAIL rr_grant[%0d]: got %b expected %b", t, req_ready, N'(1) << g); end
            model_last = g;
            lat = 0;
            do begin
                tick; lat++;
                if (rsp_valid === 4'b0) begin
                    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rr_busy[%0d]: got %b expected 1", t, busy); end
                end
            end while (rsp_valid === 4'b0 && lat < 8);
            checks++; if (lat != 3) begin failures++; $display("FAIL rr_latency[%0d]: got %0d expected 3", t, lat); end
            checks++; if (rsp_valid !== (N'(1) << g)) begin failures++; $display("FAIL rr_rsp_valid[%0d]: got %b expected %b", t, rsp_valid, N'(1) << g); end
            checks++; if (rsp_data !== 32'h101 + 32'(g)) begin failures++; $display("FAIL rr_rsp_data[%0d]: got %0h expected %0h", t, rsp_data, 32'h101 + 32'(g)); end
            tick; model_cnt = (model_cnt + 1) % 16;
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rr_idle_gap[%0d]: got %b expected 0", t, busy); end
            checks++; if (txn_count !== CW'(model_cnt)) begin failures++; $display("FAIL rr_txn_count[%0d]: got %0d expected %0d", t, txn_count, model_cnt); end
        end
        req_valid = '0;
    endtask

    task automatic test_core_backpressure();
        int r, g;
        logic [DW-1:0] d;
        tick;
        r = int'($urandom_range(0, N - 1)); d = $urandom;
        stall = 1'b1; set_word(r, d); req_valid = N'(1) << r; #1;
        g = winner(req_valid, model_last);
        checks++; if (req_ready !== (N'(1) << g)) begin failures++; $display("FAIL cbp_accept: got %b expected %b", req_ready, N'(1) << g); end
        tick; req_valid = '0; model_last = g;
        for (int i = 0; i < 5; i++) begin
            checks++; if (core_valid !== 1'b1 || core_wdata !== d) begin failures++; $display("FAIL cbp_hold[%0d]: got cv=%b wdata=%0h expected 1 %0h", i, core_valid, core_wdata, d); end
            checks++; if (rsp_valid !== 4'b0) begin failures++; $display("FAIL cbp_no_rsp[%0d]: got %b expected 0000", i, rsp_valid); end
            tick;
        end
        checks++; if (core_valid !== 1'b1) begin failures++; $display("FAIL cbp_still_issue: got %b expected 1", core_valid); end
        stall = 1'b0;
        tick;
        checks++; if (core_valid !== 1'b0 || rsp_valid !== 4'b0) begin failures++; $display("FAIL cbp_wait: got cv=%b rv=%b expected 0 0000", core_valid, rsp_valid); end
        tick;
        checks++; if (rsp_valid !== (N'(1) << g) || rsp_data !== d + 32'd1) begin failures++; $display("FAIL cbp_rsp: got rv=%b data=%0h expected %b %0h", rsp_valid, rsp_data, N'(1) << g, d + 32'd1); end
        tick; model_cnt = (model_cnt + 1) % 16;
        checks++; if (txn_count !== CW'(model_cnt)) begin failures++; $display("FAIL cbp_txn_count: got %0d expected %0d", txn_count, model_cnt); end
    endtask

    task automatic test_rsp_backpressure();
        int g;
        logic [DW-1:0] d;
        d = $urandom; set_word(2, d); req_valid = 4'b0100; rsp_ready = '1; #1;
        g = winner(req_valid, model_last);
        checks++; if (req_ready !== (N'(1) << g)) begin failures++; $display("FAIL rbp_accept: got %b expected %b", req_ready, N'(1) << g); end
        tick; req_valid = '0; model_last = g; rsp_ready = 4'($urandom) & 4'b1011;
        tick; tick;
        for (int i = 0; i < 6; i++) begin
            rsp_ready = 4'($urandom) & 4'b1011;
            req_valid = 4'($urandom) & 4'b1011; #1;
            checks++; if (rsp_valid !== 4'b0100 || rsp_data !== d + 32'd1) begin failures++; $display("FAIL rbp_hold[%0d]: got rv=%b data=%0h expected 0100 %0h", i, rsp_valid, rsp_data, d + 32'd1); end
            checks++; if (req_ready !== 4'b0 || grant_id !== 2'd2) begin failures++; $display("FAIL rbp_no_grant[%0d]: got rr=%b gid=%0d expected 0000 2", i, req_ready, grant_id); end
            checks++; if (txn_count !== CW'(model_cnt)) begin failures++; $display("FAIL rbp_count_held[%0d]: got %0d expected %0d", i, txn_count, model_cnt); end
            tick;
        end
        rsp_ready = 4'b0100; req_valid = '0; #1;
        checks++; if (rsp_valid !== 4'b0100) begin failures++; $display("FAIL rbp_still_resp: got %b expected 0100", rsp_valid); end
        tick; model_cnt = (model_cnt + 1) % 16; rsp_ready = '1;
        checks++; if (txn_count !== CW'(model_cnt) || rsp_valid !== 4'b0) begin failures++; $display("FAIL rbp_release: got cnt=%0d rv=%b expected %0d 0000", txn_count, rsp_valid, model_cnt); end
    endtask

    task automatic test_reset_in_wait();
        int lat;
        logic [DW-1:0] d;
        d = $urandom; set_word(3, d); req_valid = 4'b1000; rsp_ready = '1; #1;
        checks++; if (req_ready !== (N'(1) << winner(req_valid, model_last))) begin failures++; $display("FAIL riw_accept: got %b expected 1000", req_ready); end
        tick; req_valid = '0;
        tick;
        checks++; if (busy !== 1'b1 || core_valid !== 1'b0 || rsp_valid !== 4'b0) begin failures++; $display("FAIL riw_in_wait: got busy=%b cv=%b rv=%b expected 1 0 0000", busy, core_valid, rsp_valid); end
        reset = 1'b1;
        tick;
        checks++; if (rsp_valid !== 4'b0 || busy !== 1'b0 || core_valid !== 1'b0) begin failures++; $display("FAIL riw_outputs: got rv=%b busy=%b cv=%b expected 0000 0 0", rsp_valid, busy, core_valid); end
        checks++; if (core_wdata !== 32'h0 || rsp_data !== 32'h0 || txn_count !== 4'h0) begin failures++; $display("FAIL riw_regs: got wdata=%0h rdata=%0h cnt=%0d expected 0 0 0", core_wdata, rsp_data, txn_count); end
        checks++; if (grant_id !== 2'(N - 1)) begin failures++; $display("FAIL riw_grant_id: got %0d expected %0d", grant_id, N - 1); end
        reset = 1'b0; model_last = N - 1; model_cnt = 0;
        d = $urandom; set_word(0, d); req_valid = 4'b0001; #1;
        checks++; if (req_ready !== (N'(1) << winner(req_valid, model_last))) begin failures++; $display("FAIL riw_new_accept: got %b expected 0001", req_ready); end
        model_last = 0;
        tick; req_valid = '0;
        lat = 0;
        while (rsp_valid === 4'b0 && lat < 10) begin tick; lat++; end
        checks++; if (rsp_valid !== 4'b0001 || rsp_data !== d + 32'd1) begin failures++; $display("FAIL riw_new_rsp: got rv=%b data=%0h expected 0001 %0h", rsp_valid, rsp_data, d + 32'd1); end
        tick; model_cnt = 1;
        checks++; if (txn_count !== CW'(model_cnt)) begin failures++; $display("FAIL riw_new_count: got %0d expected %0d", txn_count, model_cnt); end
    endtask

    task automatic test_wrap();
        int g, lat;
        logic [N-1:0]  v;
        logic [DW-1:0] words [N];
        apply_reset();
        for (int t = 0; t < 16; t++) begin
            v = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < int'(N); i++) begin words[i] = $urandom; set_word(i, words[i]); end
            req_valid = v; #1;
            g = winner(v, model_last);
            checks++; if (req_ready !== (N'(1) << g)) begin failures++; $display("FAIL wrap_grant[%0d]: got %b expected %b", t, req_ready, N'(1) << g); end
            model_last = g;
            tick; req_valid = '0;
            lat = 1;
            while (rsp_valid === 4'b0 && lat < 8) begin tick; lat++; end
            checks++; if (lat != 3) begin failures++; $display("FAIL wrap_latency[%0d]: got %0d expected 3", t, lat); end
            checks++; if (rsp_valid !== (N'(1) << g) || rsp_data !== words[g] + 32'd1) begin failures++; $display("FAIL wrap_rsp[%0d]: got rv=%b data=%0h expected %b %0h", t, rsp_valid, rsp_data, N'(1) << g, words[g] + 32'd1); end
            tick; model_cnt = (model_cnt + 1) % 16;
            checks++; if (txn_count !== CW'(model_cnt)) begin failures++; $display("FAIL wrap_count[%0d]: got %0d expected %0d", t, txn_count, model_cnt); end
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; rsp_ready = '1; stall = 1'b0; req_data = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_core_backpressure();
        test_rsp_backpressure();
        test_reset_in_wait();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
